card_dealer: RTL and testbench

Sequential dealer that produces 5-card poker hands for the hand evaluator. It holds a 52-card deck as a used-card bitmap and draws cards without replacement using a free-running LFSR, with a bounded-latency fallback scan. A finished hand is presented on card/suit ports whose encoding matches the evaluator inputs: rank 0=Ace, 1..12=2..King, suit 0..3.

---
 rtl/card_dealer.sv | 196 +++++++++++++++++++
 tb/tb_card_dealer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Deals 5-card hands from a 52-card used-card bitmap. A free-running LFSR proposes
// candidates, and after MAX_TRIES rejections the lowest free card is taken instead.
module card_dealer #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       deal,
  input  logic       new_deck,
  output logic       busy,
  output logic       valid,
  output logic       error,
  output logic [5:0] cards_left,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic [3:0] card4,
  output logic [3:0] card5,
  output logic [1:0] suit1,
  output logic [1:0] suit2,
  output logic [1:0] suit3,
  output logic [1:0] suit4,
  output logic [1:0] suit5
);

  localparam int              TW        = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [15:0]     LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [TW-1:0]   TRY_LIMIT = TW'(MAX_TRIES);
  localparam logic [15:0]     POLY      = 16'hB400;

  typedef enum logic {IDLE, DRAW} state_e;

  state_e        stateQ, stateD;
  logic [15:0]   lfsrQ, lfsrD;
  logic [51:0]   usedQ, usedD;
  logic [5:0]    leftQ, leftD;
  logic [TW-1:0] triesQ, triesD;
  logic [2:0]    slotQ, slotD;
  logic          validQ, validD;
  logic          errorQ, errorD;
  logic [3:0]    rankQ [5];
  logic [1:0]    suitQ [5];

  logic [63:0]   usedExt;
  logic [5:0]    cand, scanIdx, pick;
  logic          candFree, take;
  logic [3:0]    pickRank;
  logic [1:0]    pickSuit;

  assign lfsrD = {1'b0, lfsrQ[15:1]} ^ (lfsrQ[0] ? POLY : 16'h0000);
  assign cand  = lfsrQ[5:0];

  // Indices 52..63 read as permanently used, so out-of-deck candidates reject themselves.
  assign usedExt  = {12'hFFF, usedQ};
  assign candFree = ~usedExt[cand];

  always_comb begin
    scanIdx = 6'd0;
    for (int i = 51; i >= 0; i--) begin
      if (!usedQ[i]) scanIdx = 6'(i);
    end
  end

  always_comb begin
    take = 1'b0;
    pick = scanIdx;
    if (stateQ == DRAW && !new_deck) begin
      if (triesQ == TRY_LIMIT) begin
        take = 1'b1;
      end else if (candFree) begin
        take = 1'b1;
        pick = cand;
      end
    end
  end

  // Suit by range compare instead of dividing by 13.
  always_comb begin
    if (pick >= 6'd39) begin
      pickSuit = 2'd3;
      pickRank = 4'(pick - 6'd39);
    end else if (pick >= 6'd26) begin
      pickSuit = 2'd2;
      pickRank = 4'(pick - 6'd26);
    end else if (pick >= 6'd13) begin
      pickSuit = 2'd1;
      pickRank = 4'(pick - 6'd13);
    end else begin
      pickSuit = 2'd0;
      pickRank = 4'(pick);
    end
  end

  always_comb begin
    stateD = stateQ;
    usedD  = usedQ;
    leftD  = leftQ;
    triesD = triesQ;
    slotD  = slotQ;
    validD = validQ;
    errorD = errorQ;
    unique case (stateQ)
      IDLE: begin
        if (new_deck) begin
          usedD  = '0;
          leftD  = 6'd52;
          errorD = 1'b0;
          validD = 1'b0;
        end else if (deal) begin
          if (leftQ >= 6'd5) begin
            stateD = DRAW;
            validD = 1'b0;
            slotD  = 3'd0;
            triesD = '0;
          end else begin
            errorD = 1'b1;
          end
        end
      end
      DRAW: begin
        if (new_deck) begin
          stateD = IDLE;
          validD = 1'b0;
          usedD  = '0;
          leftD  = 6'd52;
        end else if (take) begin
          usedD  = usedQ | (52'd1 << pick);
          leftD  = leftQ - 6'd1;
          triesD = '0;
          slotD  = slotQ + 3'd1;
          if (slotQ == 3'd4) begin
            stateD = IDLE;
            validD = 1'b1;
          end
        end else begin
          triesD = triesQ + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      lfsrQ  <= LFSR_INIT;
      usedQ  <= '0;
      leftQ  <= 6'd52;
      triesQ <= '0;
      slotQ  <= 3'd0;
      validQ <= 1'b0;
      errorQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      lfsrQ  <= lfsrD;
      usedQ  <= usedD;
      leftQ  <= leftD;
      triesQ <= triesD;
      slotQ  <= slotD;
      validQ <= validD;
      errorQ <= errorD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 5; s++) begin
        rankQ[s] <= 4'd0;
        suitQ[s] <= 2'd0;
      end
    end else if (take) begin
      for (int s = 0; s < 5; s++) begin
        if (slotQ == 3'(s)) begin
          rankQ[s] <= pickRank;
          suitQ[s] <= pickSuit;
        end
      end
    end
  end

  assign busy       = (stateQ == DRAW);
  assign valid      = validQ;
  assign error      = errorQ;
  assign cards_left = leftQ;
  assign card1      = rankQ[0];
  assign card2      = rankQ[1];
  assign card3      = rankQ[2];
  assign card4      = rankQ[3];
  assign card5      = rankQ[4];
  assign suit1      = suitQ[0];
  assign suit2      = suitQ[1];
  assign suit3      = suitQ[2];
  assign suit4      = suitQ[3];
  assign suit5      = suitQ[4];

endmodule

// File: tb/tb_card_dealer.sv
// Drives three dealers (default, MAX_TRIES=0, SEED=0) with shared randomized stimulus and
// predicts every hand, latency and flag from a deck-as-array model of the dealing rules.
module tb_card_dealer;

  logic clk, rst_n, deal, newDeck;
  logic [2:0]            busyV, validV, errorV;
  logic [2:0][5:0]       leftV;
  logic [2:0][4:0][3:0]  rankV;
  logic [2:0][4:0][1:0]  suitV;

  int checks = 0;
  int failures = 0;

  logic [15:0] mLfsr [3];
  bit          mUsed [3][52];
  int          mLeft [3];
  bit          mValid [3];
  bit          mErr [3];
  int          mCard [3][5];
  int          pendCard [3][5];
  int          pendCycles [3];
  int          maxTries [3] = '{64, 0, 64};
  logic [15:0] seedOf [3]   = '{16'hACE1, 16'hACE1, 16'h0001};

  card_dealer dutA (
    .clk(clk), .rst_n(rst_n), .deal(deal), .new_deck(newDeck),
    .busy(busyV[0]), .valid(validV[0]), .error(errorV[0]), .cards_left(leftV[0]),
    .card1(rankV[0][0]), .card2(rankV[0][1]), .card3(rankV[0][2]), .card4(rankV[0][3]), .card5(rankV[0][4]),
    .suit1(suitV[0][0]), .suit2(suitV[0][1]), .suit3(suitV[0][2]), .suit4(suitV[0][3]), .suit5(suitV[0][4])
  );

  card_dealer #(.MAX_TRIES(0)) dutB (
    .clk(clk), .rst_n(rst_n), .deal(deal), .new_deck(newDeck),
    .busy(busyV[1]), .valid(validV[1]), .error(errorV[1]), .cards_left(leftV[1]),
    .card1(rankV[1][0]), .card2(rankV[1][1]), .card3(rankV[1][2]), .card4(rankV[1][3]), .card5(rankV[1][4]),
    .suit1(suitV[1][0]), .suit2(suitV[1][1]), .suit3(suitV[1][2]), .suit4(suitV[1][3]), .suit5(suitV[1][4])
  );

  card_dealer #(.SEED(16'h0000)) dutC (
    .clk(clk), .rst_n(rst_n), .deal(deal), .new_deck(newDeck),
    .busy(busyV[2]), .valid(validV[2]), .error(errorV[2]), .cards_left(leftV[2]),
    .card1(rankV[2][0]), .card2(rankV[2][1]), .card3(rankV[2][2]), .card4(rankV[2][3]), .card5(rankV[2][4]),
    .suit1(suitV[2][0]), .suit2(suitV[2][1]), .suit3(suitV[2][2]), .suit4(suitV[2][3]), .suit5(suitV[2][4])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // The model's LFSR runs beside each dealer so the draw start value is known at every deal.
  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) mLfsr[d] <= seedOf[d];
      else        mLfsr[d] <= lfsrStep(mLfsr[d]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic void predictHand(input int d, input logic [15:0] start);
    logic [15:0] l;
    int tries, cyc, got, c;
    l = start;
    tries = 0;
    cyc = 0;
    for (int s = 0; s < 5; s++) begin
      got = -1;
      while (got < 0) begin
        c = int'(l[5:0]);
        cyc++;
        if (tries == maxTries[d]) begin
          for (int i = 51; i >= 0; i--) if (!mUsed[d][i]) got = i;
        end else if (c < 52 && !mUsed[d][c]) begin
          got = c;
        end else begin
          tries++;
        end
        l = lfsrStep(l);
      end
      mUsed[d][got] = 1'b1;
      pendCard[d][s] = got;
      tries = 0;
    end
    pendCycles[d] = cyc;
  endfunction

  function automatic void clearDeck(input int d);
    for (int i = 0; i < 52; i++) mUsed[d][i] = 1'b0;
    mLeft[d]  = 52;
    mValid[d] = 1'b0;
    mErr[d]   = 1'b0;
  endfunction

  task automatic checkCards(input int d);
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("rank%0d.%0d", d, s), rankV[d][s], mCard[d][s] % 13);
      checkOutput($sformatf("suit%0d.%0d", d, s), suitV[d][s], mCard[d][s] / 13);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      clearDeck(d);
      for (int s = 0; s < 5; s++) mCard[d][s] = 0;
      checkOutput($sformatf("rstBusy%0d", d), busyV[d], 0);
      checkOutput($sformatf("rstValid%0d", d), validV[d], 0);
      checkOutput($sformatf("rstError%0d", d), errorV[d], 0);
      checkOutput($sformatf("rstLeft%0d", d), leftV[d], 52);
      checkCards(d);
    end
    rst_n = 1'b1;
  endtask

  task automatic applyNewDeck(input bit withDeal);
    deal = withDeal;
    newDeck = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    newDeck = 1'b0;
    for (int d = 0; d < 3; d++) begin
      clearDeck(d);
      checkOutput($sformatf("ndBusy%0d", d), busyV[d], 0);
      checkOutput($sformatf("ndValid%0d", d), validV[d], 0);
      checkOutput($sformatf("ndError%0d", d), errorV[d], 0);
      checkOutput($sformatf("ndLeft%0d", d), leftV[d], 52);
    end
  endtask

  // One deal request; optionally a stray deal one cycle into DRAW, or new_deck two cycles in.
  task automatic applyStimulus(input bit busyDeal, input bit abort);
    bit acc [3];
    bit done [3];
    int lat [3];
    bit anyAcc, allDone;
    anyAcc = 1'b0;
    for (int d = 0; d < 3; d++) begin
      acc[d]  = (mLeft[d] >= 5);
      done[d] = 1'b0;
      lat[d]  = -1;
      if (acc[d]) begin
        anyAcc = 1'b1;
        predictHand(d, lfsrStep(mLfsr[d]));
      end
    end
    deal = 1'b1;
    @(negedge clk);
    deal = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (acc[d]) begin
        mValid[d] = 1'b0;
        checkOutput($sformatf("busyRise%0d", d), busyV[d], 1);
        checkOutput($sformatf("validDrop%0d", d), validV[d], 0);
      end else begin
        mErr[d] = 1'b1;
        checkOutput($sformatf("refErr%0d", d), errorV[d], 1);
        checkOutput($sformatf("refBusy%0d", d), busyV[d], 0);
        checkOutput($sformatf("refValid%0d", d), validV[d], mValid[d]);
        checkOutput($sformatf("refLeft%0d", d), leftV[d], mLeft[d]);
        if (mValid[d]) checkCards(d);
      end
    end
    if (!anyAcc) return;
    for (int k = 1; k <= 400; k++) begin
      if (k == 1 && busyDeal) deal = 1'b1;
      if (k == 2 && abort) newDeck = 1'b1;
      @(negedge clk);
      deal = 1'b0;
      newDeck = 1'b0;
      if (k == 2 && abort) begin
        for (int d = 0; d < 3; d++) begin
          clearDeck(d);
          checkOutput($sformatf("abBusy%0d", d), busyV[d], 0);
          checkOutput($sformatf("abValid%0d", d), validV[d], 0);
          checkOutput($sformatf("abLeft%0d", d), leftV[d], 52);
        end
        return;
      end
      allDone = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (acc[d] && !done[d]) begin
          if (validV[d]) begin
            done[d] = 1'b1;
            lat[d] = k;
          end else begin
            allDone = 1'b0;
          end
        end
      end
      if (allDone) break;
    end
    for (int d = 0; d < 3; d++) begin
      if (acc[d]) begin
        checkOutput($sformatf("latency%0d", d), lat[d], pendCycles[d]);
        mValid[d] = 1'b1;
        mLeft[d] -= 5;
        for (int s = 0; s < 5; s++) mCard[d][s] = pendCard[d][s];
        checkOutput($sformatf("doneBusy%0d", d), busyV[d], 0);
        checkOutput($sformatf("doneValid%0d", d), validV[d], 1);
        checkOutput($sformatf("doneLeft%0d", d), leftV[d], mLeft[d]);
        checkCards(d);
      end
    end
  endtask

  task automatic runDirected();
    int r3 [5] = '{10, 11, 12, 0, 1};
    int s3 [5] = '{0, 0, 0, 1, 1};
    applyReset();
    repeat (2) @(negedge clk);
    for (int h = 0; h < 10; h++) begin
      applyStimulus(1'b0, 1'b0);
      for (int s = 0; s < 5; s++) begin
        if (h == 0) begin
          checkOutput("scanHand1Rank", rankV[1][s], s);
          checkOutput("scanHand1Suit", suitV[1][s], 0);
        end else if (h == 1) begin
          checkOutput("scanHand2Rank", rankV[1][s], s + 5);
          checkOutput("scanHand2Suit", suitV[1][s], 0);
        end else if (h == 2) begin
          checkOutput("scanHand3Rank", rankV[1][s], r3[s]);
          checkOutput("scanHand3Suit", suitV[1][s], s3[s]);
        end
      end
    end
    checkOutput("tenDealsLeft", leftV[0], 2);
  endtask

  initial begin
    int r;
    rst_n = 1'b1;
    deal = 1'b0;
    newDeck = 1'b0;
    #2;
    runDirected();
    applyStimulus(1'b0, 1'b0);
    applyNewDeck(1'b0);
    applyNewDeck(1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      checkOutput("postAbortRank", rankV[1][s], s);
      checkOutput("postAbortSuit", suitV[1][s], 0);
    end
    applyStimulus(1'b1, 1'b0);
    runDirected();
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       applyNewDeck(r[0]);
      else if (r < 18) applyStimulus(1'b0, 1'b1);
      else if (r < 30) applyStimulus(1'b1, 1'b0);
      else             applyStimulus(1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
